// File: rtl/rs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs_pkg
//  Description : Shared constants and types for the age-ordered reservation
//                station: fixed op-field widths, RISC-V major opcodes and the
//                decoded op-field bundle carried by every entry.
//  Revision    : 1.0 - initial release
// ============================================================================
package rs_pkg;

    localparam int c_opcode_w = 7;
    localparam int c_func3_w  = 3;
    localparam int c_ctrl_w   = 10;
    localparam int c_pc_w     = 10;
    localparam int c_reg_w    = 5;

    localparam logic [c_opcode_w-1:0] c_opc_op     = 7'b0110011;
    localparam logic [c_opcode_w-1:0] c_opc_op_imm = 7'b0010011;
    localparam logic [c_opcode_w-1:0] c_opc_load   = 7'b0000011;
    localparam logic [c_opcode_w-1:0] c_opc_store  = 7'b0100011;
    localparam logic [c_opcode_w-1:0] c_opc_branch = 7'b1100011;

    // Width-independent part of a micro-op; operand and tag fields depend on
    // the station's parameters and are bundled in the top module.
    typedef struct packed {
        logic [c_opcode_w-1:0] opcode;
        logic [c_func3_w-1:0]  func3;
        logic [c_ctrl_w-1:0]   control;
        logic [c_pc_w-1:0]     pc;
        logic [c_reg_w-1:0]    rd_reg;
    } rs_op_t;

endpackage
`default_nettype wire

// File: rtl/rs_age_select.sv
`default_nettype none
// ============================================================================
//  Module      : rs_age_select
//  Description : Age matrix plus oldest-ready picker.
//                Row i bit j set means entry j was already resident when i was
//                allocated, i.e. j is older than i and blocks it.
//  Ports       : i_alloc_en/i_alloc_idx - slot being written this cycle
//                i_valid                - registered occupancy vector
//                i_ready                - issue candidates (valid and ready)
//                o_grant/o_grant_idx    - one-hot and encoded oldest candidate
//                o_grant_valid          - some candidate exists
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_age_select #(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_alloc_en,
    input  logic [IDX_W-1:0] i_alloc_idx,
    input  logic [DEPTH-1:0] i_valid,
    input  logic [DEPTH-1:0] i_ready,
    output logic [DEPTH-1:0] o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_grant_valid
);

    logic [DEPTH-1:0] r_age [DEPTH];

    // A new entry is younger than everything resident: its row marks all of
    // them, and its column is cleared in their rows. Stale bits of freed
    // slots are harmless because the slot rewrites both on reallocation.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_age[i] <= '0;
        end else if (i_alloc_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (IDX_W'(i) == i_alloc_idx) r_age[i] <= i_valid;
                else                          r_age[i][i_alloc_idx] <= 1'b0;
            end
        end
    end

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_grant[i] = i_ready[i] && ((r_age[i] & i_ready) == '0);
            if (o_grant[i]) o_grant_idx = IDX_W'(i);
        end
        o_grant_valid = |o_grant;
    end

endmodule
`default_nettype wire

// File: rtl/rs_age_queue.sv
`default_nettype none
// ============================================================================
//  Module      : rs_age_queue
//  Description : DEPTH-entry reservation station with NUM_CDB result-broadcast
//                ports, oldest-ready issue, stall back-pressure and flush.
//  Ports       : in_*      - dispatch request (in_ready from registered count)
//                cdb_*     - packed broadcast ports, port 0 in the LSBs
//                stall     - execution unit busy, outputs and entries hold
//                flush     - discard all entries and the pending issue
//                out_*     - registered issued micro-op, count - occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module rs_age_queue
    import rs_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int NUM_CDB = 4,
    parameter int DATA_W  = 32,
    parameter int PHY_W   = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [6:0]                  in_opcode,
    input  logic [2:0]                  in_func3,
    input  logic [9:0]                  in_control,
    input  logic [9:0]                  in_pc,
    input  logic [DATA_W-1:0]           in_label,
    input  logic [PHY_W-1:0]            in_rd_phy,
    input  logic [4:0]                  in_rd_reg,
    input  logic [DATA_W-1:0]           in_operand1,
    input  logic [DATA_W-1:0]           in_operand2,
    input  logic [PHY_W-1:0]            in_phy_add1,
    input  logic [PHY_W-1:0]            in_phy_add2,
    input  logic [1:0]                  in_src_rdy,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*PHY_W-1:0]    cdb_phy,
    input  logic [NUM_CDB*DATA_W-1:0]   cdb_data,
    input  logic                        stall,
    input  logic                        flush,
    output logic                        out_valid,
    output logic [$clog2(DEPTH)-1:0]    out_rs_add,
    output logic [6:0]                  out_opcode,
    output logic [2:0]                  out_func3,
    output logic [9:0]                  out_control,
    output logic [9:0]                  out_pc,
    output logic [DATA_W-1:0]           out_label,
    output logic [PHY_W-1:0]            out_rd_phy,
    output logic [4:0]                  out_rd_reg,
    output logic [DATA_W-1:0]           out_operand1,
    output logic [DATA_W-1:0]           out_operand2,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int c_idx_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_idx_w + 1;

    typedef struct packed {
        logic              rdy;
        logic [PHY_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } src_t;

    typedef struct packed {
        rs_op_t            op;
        logic [DATA_W-1:0] label;
        logic [PHY_W-1:0]  rd_phy;
        src_t              src1;
        src_t              src2;
    } rs_entry_t;

    rs_entry_t           r_ent [DEPTH];
    logic [DEPTH-1:0]    r_valid;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_out_valid;
    logic [c_idx_w-1:0]  r_out_rs_add;
    rs_op_t              r_out_op;
    logic [DATA_W-1:0]   r_out_label;
    logic [PHY_W-1:0]    r_out_rd_phy;
    logic [DATA_W-1:0]   r_out_op1;
    logic [DATA_W-1:0]   r_out_op2;

    logic [c_idx_w-1:0]  w_free_idx;
    logic                w_alloc;
    logic                w_issue;
    logic [DEPTH-1:0]    w_cand;
    logic [DEPTH-1:0]    w_grant;
    logic [c_idx_w-1:0]  w_grant_idx;
    logic                w_grant_valid;
    rs_entry_t           w_new;

    // Capture a broadcast result into a waiting source. Ports are scanned from
    // the highest index down so the lowest matching port wins.
    function automatic src_t wake(input src_t s);
        src_t r;
        r = s;
        if (!s.rdy) begin
            for (int p = NUM_CDB - 1; p >= 0; p--) begin
                if (cdb_valid[p] && (cdb_phy[p*PHY_W +: PHY_W] == s.tag)) begin
                    r.rdy  = 1'b1;
                    r.data = cdb_data[p*DATA_W +: DATA_W];
                end
            end
        end
        return r;
    endfunction

    // No credit is taken for an issue in the same cycle.
    assign in_ready = (r_count != c_cnt_w'(DEPTH));
    assign w_alloc  = in_valid && in_ready && !flush;
    assign w_issue  = !stall && w_grant_valid;

    always_comb begin
        w_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) w_free_idx = c_idx_w'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_cand[i] = r_valid[i] && r_ent[i].src1.rdy && r_ent[i].src2.rdy;
        end
    end

    // Incoming op sees the same broadcasts as resident entries.
    always_comb begin
        w_new.op.opcode  = in_opcode;
        w_new.op.func3   = in_func3;
        w_new.op.control = in_control;
        w_new.op.pc      = in_pc;
        w_new.op.rd_reg  = in_rd_reg;
        w_new.label      = in_label;
        w_new.rd_phy     = in_rd_phy;
        w_new.src1       = wake('{rdy: in_src_rdy[1], tag: in_phy_add1, data: in_operand1});
        w_new.src2       = wake('{rdy: in_src_rdy[0], tag: in_phy_add2, data: in_operand2});
    end

    rs_age_select #(
        .DEPTH (DEPTH),
        .IDX_W (c_idx_w)
    ) u_age_select (
        .clk           (clk),
        .rst           (rst),
        .i_alloc_en    (w_alloc),
        .i_alloc_idx   (w_free_idx),
        .i_valid       (r_valid),
        .i_ready       (w_cand),
        .o_grant       (w_grant),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= '0;
            r_count      <= '0;
            r_out_valid  <= 1'b0;
            r_out_rs_add <= '0;
            r_out_op     <= '0;
            r_out_label  <= '0;
            r_out_rd_phy <= '0;
            r_out_op1    <= '0;
            r_out_op2    <= '0;
        end else if (flush) begin
            r_valid     <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_valid[i]) begin
                    r_ent[i].src1 <= wake(r_ent[i].src1);
                    r_ent[i].src2 <= wake(r_ent[i].src2);
                end
            end
            if (w_alloc) begin
                r_ent[w_free_idx]   <= w_new;
                r_valid[w_free_idx] <= 1'b1;
            end
            if (!stall) begin
                r_out_valid <= w_grant_valid;
                if (w_grant_valid) begin
                    r_out_rs_add         <= w_grant_idx;
                    r_out_op             <= r_ent[w_grant_idx].op;
                    r_out_label          <= r_ent[w_grant_idx].label;
                    r_out_rd_phy         <= r_ent[w_grant_idx].rd_phy;
                    r_out_op1            <= r_ent[w_grant_idx].src1.data;
                    r_out_op2            <= r_ent[w_grant_idx].src2.data;
                    r_valid[w_grant_idx] <= 1'b0;
                end
            end
            r_count <= r_count + c_cnt_w'(w_alloc) - c_cnt_w'(w_issue);
        end
    end

    assign out_valid    = r_out_valid;
    assign out_rs_add   = r_out_rs_add;
    assign out_opcode   = r_out_op.opcode;
    assign out_func3    = r_out_op.func3;
    assign out_control  = r_out_op.control;
    assign out_pc       = r_out_op.pc;
    assign out_rd_reg   = r_out_op.rd_reg;
    assign out_label    = r_out_label;
    assign out_rd_phy   = r_out_rd_phy;
    assign out_operand1 = r_out_op1;
    assign out_operand2 = r_out_op2;
    assign count        = r_count;

endmodule
`default_nettype wire

// File: tb/tb_rs_age_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs_age_queue
//  Description : Scoreboard bench for rs_age_queue. Directed stimulus pushes
//                the expected issued op; a monitor pops on every new issue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_age_queue;
    import rs_pkg::*;

    localparam int DEPTH   = 8;
    localparam int NUM_CDB = 4;
    localparam int DATA_W  = 32;
    localparam int PHY_W   = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst, in_valid, in_ready, stall, flush, out_valid;
    logic [6:0]                in_opcode, out_opcode;
    logic [2:0]                in_func3, out_func3;
    logic [9:0]                in_control, in_pc, out_control, out_pc;
    logic [DATA_W-1:0]         in_label, in_operand1, in_operand2;
    logic [DATA_W-1:0]         out_label, out_operand1, out_operand2;
    logic [PHY_W-1:0]          in_rd_phy, in_phy_add1, in_phy_add2, out_rd_phy;
    logic [4:0]                in_rd_reg, out_rd_reg;
    logic [1:0]                in_src_rdy;
    logic [NUM_CDB-1:0]        cdb_valid;
    logic [NUM_CDB*PHY_W-1:0]  cdb_phy;
    logic [NUM_CDB*DATA_W-1:0] cdb_data;
    logic [2:0]                out_rs_add;
    logic [3:0]                count;

    rs_age_queue #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .DATA_W(DATA_W), .PHY_W(PHY_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_func3(in_func3), .in_control(in_control),
        .in_pc(in_pc), .in_label(in_label), .in_rd_phy(in_rd_phy), .in_rd_reg(in_rd_reg),
        .in_operand1(in_operand1), .in_operand2(in_operand2),
        .in_phy_add1(in_phy_add1), .in_phy_add2(in_phy_add2), .in_src_rdy(in_src_rdy),
        .cdb_valid(cdb_valid), .cdb_phy(cdb_phy), .cdb_data(cdb_data),
        .stall(stall), .flush(flush), .out_valid(out_valid), .out_rs_add(out_rs_add),
        .out_opcode(out_opcode), .out_func3(out_func3), .out_control(out_control),
        .out_pc(out_pc), .out_label(out_label), .out_rd_phy(out_rd_phy),
        .out_rd_reg(out_rd_reg), .out_operand1(out_operand1), .out_operand2(out_operand2),
        .count(count)
    );

    typedef struct {
        int          rs_add;
        logic [6:0]  opcode;
        logic [9:0]  pc;
        logic [6:0]  rd;
        logic [31:0] op1;
        logic [31:0] op2;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic st_q, fl_q, rs_q;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic expect_issue(input int slot, input logic [6:0] opc, input int pc,
                                input int rd, input logic [31:0] o1, input logic [31:0] o2);
        exp_t e;
        e.rs_add = slot; e.opcode = opc; e.pc = 10'(pc); e.rd = 7'(rd); e.op1 = o1; e.op2 = o2;
        exp_q.push_back(e);
    endtask

    task automatic drive_op(input logic [6:0] opc, input int pc, input int rd,
                            input logic [31:0] o1, input logic [31:0] o2,
                            input int t1, input int t2, input logic [1:0] rdy);
        in_valid = 1'b1; in_opcode = opc; in_func3 = 3'd0; in_control = 10'd0;
        in_pc = 10'(pc); in_label = 32'(pc); in_rd_phy = 7'(rd); in_rd_reg = 5'(rd);
        in_operand1 = o1; in_operand2 = o2;
        in_phy_add1 = 7'(t1); in_phy_add2 = 7'(t2); in_src_rdy = rdy;
    endtask

    task automatic set_cdb(input int port, input int tag, input logic [31:0] data);
        cdb_valid[port] = 1'b1;
        cdb_phy[port*PHY_W +: PHY_W] = 7'(tag);
        cdb_data[port*DATA_W +: DATA_W] = data;
    endtask

    task automatic idle();
        in_valid = 1'b0; cdb_valid = '0;
    endtask

    // Monitor: a new issue is an out_valid following an edge that was not
    // stalled, flushed or in reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            st_q = stall; fl_q = flush; rs_q = rst;
            #1;
            if (!rs_q && !fl_q && !st_q && out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_issue actual rs_add=%0d pc=%0d required no issue",
                             out_rs_add, out_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (out_rs_add !== 3'(e.rs_add) || out_opcode !== e.opcode || out_pc !== e.pc ||
                        out_rd_phy !== e.rd || out_rd_reg !== e.rd[4:0] ||
                        out_operand1 !== e.op1 || out_operand2 !== e.op2) begin
                        failures++;
                        $display("FAIL issue_pc%0d actual slot=%0d opc=%0h pc=%0d rd=%0d op1=%0h op2=%0h required slot=%0d opc=%0h pc=%0d rd=%0d op1=%0h op2=%0h",
                                 e.pc, out_rs_add, out_opcode, out_pc, out_rd_phy, out_operand1, out_operand2,
                                 e.rs_add, e.opcode, e.pc, e.rd, e.op1, e.op2);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_opcode = '0; in_func3 = '0; in_control = '0; in_pc = '0;
        in_label = '0; in_rd_phy = '0; in_rd_reg = '0; in_operand1 = '0; in_operand2 = '0;
        in_phy_add1 = '0; in_phy_add2 = '0; in_src_rdy = '0;
        cdb_valid = '0; cdb_phy = '0; cdb_data = '0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_count", count, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_rs_add", out_rs_add, 0);
        check("reset_operand1", out_operand1, 0);
        rst = 1'b0;

        // Both sources ready: one-cycle latency.
        drive_op(c_opc_op, 1, 1, 32'd2, 32'd3, 0, 0, 2'b11);
        expect_issue(0, c_opc_op, 1, 1, 32'd2, 32'd3);
        @(negedge clk); idle();
        check("add_count_stored", count, 1);
        check("add_not_issued_yet", out_valid, 0);
        @(negedge clk);
        check("add_issued_valid", out_valid, 1);
        check("add_count_drained", count, 0);
        @(negedge clk);

        // Operand1 woken by port 0; port 3 carries the same tag and must lose.
        drive_op(c_opc_op, 2, 5, 32'd0, 32'd7, 1, 3, 2'b01);
        expect_issue(0, c_opc_op, 2, 5, 32'd5, 32'd7);
        @(negedge clk); idle();
        check("mul_waiting", out_valid, 0);
        set_cdb(0, 1, 32'd5); set_cdb(3, 1, 32'd99);
        @(negedge clk); idle();
        check("mul_woken_not_issued", out_valid, 0);
        @(negedge clk);
        check("mul_count_drained", count, 0);

        // Dispatch-cycle bypass from port 2.
        drive_op(c_opc_op, 3, 6, 32'd0, 32'd4, 1, 2, 2'b01);
        set_cdb(2, 1, 32'd5);
        expect_issue(0, c_opc_op, 3, 6, 32'd5, 32'd4);
        @(negedge clk); idle();
        @(negedge clk);
        @(negedge clk);

        // Operand2 woken by port 1.
        drive_op(c_opc_op_imm, 4, 7, 32'h20, 32'd0, 2, 9, 2'b10);
        expect_issue(0, c_opc_op_imm, 4, 7, 32'h20, 32'h11);
        @(negedge clk); idle();
        set_cdb(1, 9, 32'h11);
        @(negedge clk); idle();
        @(negedge clk);
        @(negedge clk);

        // Fill under stall, then drain oldest-first.
        stall = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            drive_op(c_opc_load, 10 + i, 10 + i, 32'(i), 32'(2 * i), 0, 0, 2'b11);
            expect_issue(i, c_opc_load, 10 + i, 10 + i, 32'(i), 32'(2 * i));
            @(negedge clk);
        end
        idle();
        check("full_count", count, DEPTH);
        check("full_in_ready", in_ready, 0);
        check("full_stalled_no_issue", out_valid, 0);
        drive_op(c_opc_load, 99, 99, 32'd1, 32'd1, 0, 0, 2'b11);
        @(negedge clk); idle();
        check("full_dispatch_ignored", count, DEPTH);
        stall = 1'b0;
        repeat (9) @(negedge clk);
        check("drain_count", count, 0);

        // Younger op in the lower slot becomes ready together with an older one.
        drive_op(c_opc_op, 30, 30, 32'd1, 32'd1, 0, 0, 2'b11);
        expect_issue(0, c_opc_op, 30, 30, 32'd1, 32'd1);
        @(negedge clk);
        drive_op(c_opc_op, 31, 31, 32'd0, 32'd2, 30, 0, 2'b01);
        expect_issue(1, c_opc_op, 31, 31, 32'h30, 32'd2);
        @(negedge clk);
        drive_op(c_opc_op, 32, 32, 32'd0, 32'd3, 30, 0, 2'b01);
        expect_issue(0, c_opc_op, 32, 32, 32'h30, 32'd3);
        @(negedge clk); idle();
        set_cdb(0, 30, 32'h30);
        @(negedge clk); idle();
        repeat (3) @(negedge clk);

        // Flush with five resident entries, stall held and a concurrent dispatch.
        drive_op(c_opc_branch, 40, 40, 32'd4, 32'd4, 0, 0, 2'b11);
        expect_issue(0, c_opc_branch, 40, 40, 32'd4, 32'd4);
        @(negedge clk); idle();
        @(negedge clk);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_op(c_opc_store, 41 + i, 41 + i, 32'd0, 32'd0, 0, 0, 2'b11);
            @(negedge clk);
        end
        idle();
        check("preflush_count", count, 5);
        check("preflush_out_held", out_valid, 1);
        flush = 1'b1;
        drive_op(c_opc_op, 50, 50, 32'd0, 32'd0, 0, 0, 2'b11);
        @(negedge clk); idle(); flush = 1'b0;
        check("flush_count", count, 0);
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        stall = 1'b0;
        repeat (4) @(negedge clk);
        check("flush_no_residual", count, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
